// File: rtl/avalon_st_if.sv
// Avalon-ST style packet stream bundle.
// Carries one beat per valid/rdy handshake with sop/eop framing.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ?
                        $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic [EW-1:0]                    empty;
    logic                             rdy;

    modport master (
        output valid, sop, eop, data, empty,
        input  rdy
    );

    modport slave (
        input  valid, sop, eop, data, empty,
        output rdy
    );
endinterface

// File: rtl/avalon_pkt_enforcer.sv
// Packet framing enforcer: repairs stray/missing sop and overlong packets.
// Hold register gives one-beat lookahead so eop can be forced on it.
module avalon_pkt_enforcer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_PKT_BEATS       = 64,
    parameter int REPAIR_MODE         = 0,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    avalon_st_if.slave               untrusted_msg,
    avalon_st_if.master              trusted_msg,
    output logic                     packet_didnt_started,
    output logic                     packet_in_packet,
    output logic                     packet_too_long,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ?
                        $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int CW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_BEATS);
    localparam bit RESTART = (REPAIR_MODE != 0);

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;

    logic          hold_valid;
    logic          hold_sop;
    logic          hold_eop;
    logic [DW-1:0] hold_data;
    logic [EW-1:0] hold_empty;

    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;

    logic          out_free;
    logic          in_rdy;
    logic          acc;
    logic          drain;
    logic [CW-1:0] cnt_next;
    logic          hit_limit;
    logic          stray;
    logic          no_start;
    logic          restart;

    assign out_free  = !out_valid || trusted_msg.rdy;
    // A held eop must leave before anything new is accepted.
    assign in_rdy    = !rst && out_free && !(hold_valid && hold_eop);
    assign acc       = untrusted_msg.valid && in_rdy;
    assign drain     = out_free && hold_valid && hold_eop;
    assign cnt_next  = beat_cnt + 1'b1;

    assign hit_limit = acc && (state == IN_PKT) &&
                       !untrusted_msg.eop && (cnt_next == MAX_CNT);
    assign stray     = acc && (state == IN_PKT) &&
                       untrusted_msg.sop && !hit_limit;
    assign no_start  = acc && (state == IDLE) && !untrusted_msg.sop;
    assign restart   = stray && RESTART;

    assign untrusted_msg.rdy = in_rdy;
    assign trusted_msg.valid = out_valid;
    assign trusted_msg.sop   = out_sop;
    assign trusted_msg.eop   = out_eop;
    assign trusted_msg.data  = out_data;
    assign trusted_msg.empty = out_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            beat_cnt             <= '0;
            hold_valid           <= 1'b0;
            hold_sop             <= 1'b0;
            hold_eop             <= 1'b0;
            hold_data            <= '0;
            hold_empty           <= '0;
            out_valid            <= 1'b0;
            out_sop              <= 1'b0;
            out_eop              <= 1'b0;
            out_data             <= '0;
            out_empty            <= '0;
            packet_didnt_started <= 1'b0;
            packet_in_packet     <= 1'b0;
            packet_too_long      <= 1'b0;
            error_count          <= '0;
        end else begin
            packet_didnt_started <= no_start;
            packet_in_packet     <= stray;
            packet_too_long      <= hit_limit;
            if ((no_start || stray || hit_limit) && error_count != '1)
                error_count <= error_count + 1'b1;

            if (trusted_msg.rdy)
                out_valid <= 1'b0;

            if (drain) begin
                out_valid  <= 1'b1;
                out_sop    <= hold_sop;
                out_eop    <= hold_eop;
                out_data   <= hold_data;
                out_empty  <= hold_empty;
                hold_valid <= 1'b0;
            end

            if (acc) begin
                unique case (state)
                    IDLE: begin
                        if (untrusted_msg.sop) begin
                            hold_valid <= 1'b1;
                            hold_sop   <= 1'b1;
                            hold_eop   <= untrusted_msg.eop;
                            hold_data  <= untrusted_msg.data;
                            hold_empty <= untrusted_msg.empty;
                            beat_cnt   <= CW'(1);
                            state      <= untrusted_msg.eop ? IDLE : IN_PKT;
                        end
                    end
                    IN_PKT: begin
                        // Restart closes the held beat before it moves out.
                        out_valid  <= 1'b1;
                        out_sop    <= hold_sop;
                        out_eop    <= restart ? 1'b1 : hold_eop;
                        out_data   <= hold_data;
                        out_empty  <= restart ? '0 : hold_empty;
                        hold_valid <= 1'b1;
                        hold_data  <= untrusted_msg.data;
                        if (hit_limit) begin
                            hold_sop   <= 1'b0;
                            hold_eop   <= 1'b1;
                            hold_empty <= '0;
                            beat_cnt   <= cnt_next;
                            state      <= DROP;
                        end else begin
                            hold_sop   <= restart;
                            hold_eop   <= untrusted_msg.eop;
                            hold_empty <= untrusted_msg.empty;
                            beat_cnt   <= restart ? CW'(1) : cnt_next;
                            state      <= untrusted_msg.eop ? IDLE : IN_PKT;
                        end
                    end
                    DROP: begin
                        if (untrusted_msg.eop)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_avalon_pkt_enforcer.sv
// Bench for avalon_pkt_enforcer: MERGE and RESTART instances in lockstep.
// Expected beats come from a list-level framing model.
module tb_avalon_pkt_enforcer;
    localparam int MAXB = 4;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
        logic [1:0]  empty;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) m_in ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) m_out ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) r_in ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) r_out ();

    logic        m_ns, m_pip, m_long;
    logic [1:0]  m_err;
    logic        r_ns, r_pip, r_long;
    logic [15:0] r_err;

    avalon_pkt_enforcer #(
        .DATA_WIDTH_IN_BYTES(4), .MAX_PKT_BEATS(MAXB),
        .REPAIR_MODE(0), .ERR_CNT_WIDTH(2)
    ) u_merge (
        .clk(clk), .rst(rst),
        .untrusted_msg(m_in), .trusted_msg(m_out),
        .packet_didnt_started(m_ns), .packet_in_packet(m_pip),
        .packet_too_long(m_long), .error_count(m_err)
    );

    avalon_pkt_enforcer #(
        .DATA_WIDTH_IN_BYTES(4), .MAX_PKT_BEATS(MAXB),
        .REPAIR_MODE(1), .ERR_CNT_WIDTH(16)
    ) u_restart (
        .clk(clk), .rst(rst),
        .untrusted_msg(r_in), .trusted_msg(r_out),
        .packet_didnt_started(r_ns), .packet_in_packet(r_pip),
        .packet_too_long(r_long), .error_count(r_err)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    bp       = 0;
    int    gap_max  = 0;
    string nm[2]    = '{"m", "r"};

    beat_t expm[$];
    beat_t expr[$];
    int    mn[2], exp_ns[2], exp_pip[2], exp_long[2];
    bit    mdrop[2];
    int    seen_ns[2], seen_pip[2], seen_long[2], outs[2];
    bit    stall[2];
    beat_t prev[2];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qpush(input int k, input beat_t b);
        if (k == 0) expm.push_back(b);
        else        expr.push_back(b);
    endtask

    // Framing rules applied to the accepted beat list.
    task automatic model(input int k, input beat_t b);
        beat_t o, t;
        o = b;
        if (mdrop[k]) begin
            if (b.eop) mdrop[k] = 1'b0;
        end else if (mn[k] == 0) begin
            if (!b.sop) exp_ns[k]++;
            else begin
                mn[k] = b.eop ? 0 : 1;
                qpush(k, o);
            end
        end else if (!b.eop && mn[k] + 1 == MAXB) begin
            o.sop = 1'b0; o.eop = 1'b1; o.empty = '0;
            qpush(k, o);
            exp_long[k]++;
            mn[k] = 0;
            mdrop[k] = 1'b1;
        end else begin
            if (b.sop) begin
                exp_pip[k]++;
                if (k == 1 && expr.size() > 0) begin
                    t = expr.pop_back();
                    t.eop = 1'b1; t.empty = '0;
                    expr.push_back(t);
                    mn[k] = 0;
                end else begin
                    o.sop = 1'b0;
                end
            end
            mn[k] = b.eop ? 0 : mn[k] + 1;
            qpush(k, o);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; mdrop[k] = 0;
            exp_ns[k] = 0; exp_pip[k] = 0; exp_long[k] = 0;
            seen_ns[k] = 0; seen_pip[k] = 0; seen_long[k] = 0;
            outs[k] = 0; stall[k] = 0;
        end
        expm.delete();
        expr.delete();
    endtask

    task automatic mon(input int k, input logic v, input logic rdy,
                       input beat_t b);
        beat_t e;
        if (stall[k]) begin
            check({nm[k], "_stall_valid"}, v, 1'b1);
            check({nm[k], "_stall_beat"}, b, prev[k]);
        end
        if (v && rdy) begin
            outs[k]++;
            if ((k == 0 ? expm.size() : expr.size()) == 0) begin
                check({nm[k], "_unexpected_beat"}, b, 64'hdead);
            end else begin
                e = (k == 0) ? expm.pop_front() : expr.pop_front();
                check({nm[k], "_beat"}, b, e);
            end
        end
        stall[k] = v && !rdy;
        prev[k]  = b;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall[0] = 0;
                stall[1] = 0;
            end else begin
                mon(0, m_out.valid, m_out.rdy,
                    {m_out.sop, m_out.eop, m_out.data, m_out.empty});
                mon(1, r_out.valid, r_out.rdy,
                    {r_out.sop, r_out.eop, r_out.data, r_out.empty});
                if (m_ns)   seen_ns[0]++;
                if (m_pip)  seen_pip[0]++;
                if (m_long) seen_long[0]++;
                if (r_ns)   seen_ns[1]++;
                if (r_pip)  seen_pip[1]++;
                if (r_long) seen_long[1]++;
                check("m_one_pulse",
                      64'($countones({m_ns, m_pip, m_long}) <= 1), 1);
                check("r_one_pulse",
                      64'($countones({r_ns, r_pip, r_long}) <= 1), 1);
            end
        end
    end

    initial begin
        m_out.rdy = 1'b1;
        r_out.rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp)
                0:       m_out.rdy = 1'b1;
                1:       m_out.rdy = !m_out.rdy;
                default: m_out.rdy = 1'($urandom_range(0, 1));
            endcase
            r_out.rdy = m_out.rdy;
        end
    end

    task automatic send(input logic s, input logic e,
                        input logic [31:0] d, input logic [1:0] em);
        bit dm, dr;
        int g;
        model(0, {s, e, d, em});
        model(1, {s, e, d, em});
        m_in.sop = s; m_in.eop = e; m_in.data = d; m_in.empty = em;
        r_in.sop = s; r_in.eop = e; r_in.data = d; r_in.empty = em;
        m_in.valid = 1'b1;
        r_in.valid = 1'b1;
        dm = 0; dr = 0; g = 0;
        while (!(dm && dr) && g < 200) begin
            @(negedge clk);
            if (m_in.valid && m_in.rdy) dm = 1;
            if (r_in.valid && r_in.rdy) dr = 1;
            @(posedge clk); #1;
            if (dm) m_in.valid = 1'b0;
            if (dr) r_in.valid = 1'b0;
            g++;
        end
        check("send_accepted", {dm, dr}, 2'b11);
        m_in.valid = 1'b0;
        r_in.valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic settle(input string tag);
        int g, t0, t1;
        g = 0;
        while ((expm.size() != 0 || expr.size() != 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_drained"}, expm.size() + expr.size(), 0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_", nm[k], "_didnt_started"}, seen_ns[k], exp_ns[k]);
            check({tag, "_", nm[k], "_in_packet"}, seen_pip[k], exp_pip[k]);
            check({tag, "_", nm[k], "_too_long"}, seen_long[k], exp_long[k]);
        end
        t0 = exp_ns[0] + exp_pip[0] + exp_long[0];
        t1 = exp_ns[1] + exp_pip[1] + exp_long[1];
        check({tag, "_m_err_count"}, m_err, (t0 > 3) ? 3 : t0);
        check({tag, "_r_err_count"}, r_err, (t1 > 65535) ? 65535 : t1);
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_m_valid"}, m_out.valid, 0);
        check({tag, "_m_sop_eop"}, {m_out.sop, m_out.eop}, 0);
        check({tag, "_m_data"}, {m_out.data, m_out.empty}, 0);
        check({tag, "_m_rdy"}, m_in.rdy, 0);
        check({tag, "_m_err"}, m_err, 0);
        check({tag, "_m_pulses"}, {m_ns, m_pip, m_long}, 0);
        check({tag, "_r_valid"}, r_out.valid, 0);
        check({tag, "_r_sop_eop"}, {r_out.sop, r_out.eop}, 0);
        check({tag, "_r_data"}, {r_out.data, r_out.empty}, 0);
        check({tag, "_r_rdy"}, r_in.rdy, 0);
        check({tag, "_r_err"}, r_err, 0);
        check({tag, "_r_pulses"}, {r_ns, r_pip, r_long}, 0);
    endtask

    initial begin
        m_in.valid = 0; m_in.sop = 0; m_in.eop = 0;
        m_in.data = 0; m_in.empty = 0;
        r_in.valid = 0; r_in.sop = 0; r_in.eop = 0;
        r_in.data = 0; r_in.empty = 0;
        clear_model();

        repeat (2) @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean 4-beat packet with eop latency check.
        send(1, 0, 32'h22222222, 0);
        send(0, 0, 32'h22222222, 0);
        send(0, 0, 32'h22222222, 0);
        send(0, 1, 32'h22222222, 2'd1);
        @(negedge clk);
        check("eop_not_early", {m_out.eop, r_out.eop}, 2'b00);
        @(negedge clk);
        check("eop_two_cycles",
              {m_out.valid & m_out.eop, r_out.valid & r_out.eop}, 2'b11);
        @(posedge clk); #1;
        settle("clean");

        send(0, 0, 32'h0bad0bad, 0);
        send(1, 0, 32'h10000001, 0);
        send(0, 1, 32'h10000002, 2'd3);
        settle("no_sop");

        send(1, 0, 32'haaaa0001, 0);
        send(0, 0, 32'haaaa0002, 2'd2);
        send(1, 0, 32'hbbbb0001, 0);
        send(0, 1, 32'hbbbb0002, 2'd1);
        settle("stray_sop");

        for (int i = 1; i <= 7; i++)
            send(i == 1, i == 7, 32'hc0de0000 + 32'(i), 2'd3);
        send(1, 0, 32'hd0000001, 0);
        send(0, 1, 32'hd0000002, 2'd2);
        settle("too_long");

        bp = 1;
        gap_max = 2;
        for (int i = 1; i <= 4; i++)
            send(i == 1, i == 4, 32'h22222222, 0);
        send(1, 0, 32'haaaa0001, 0);
        send(0, 0, 32'haaaa0002, 2'd2);
        send(1, 0, 32'hbbbb0001, 0);
        send(0, 1, 32'hbbbb0002, 2'd1);
        settle("toggle_rdy");

        bp = 0;
        gap_max = 0;
        for (int i = 0; i < 5; i++)
            send(0, 0, 32'h5a5a0000 + 32'(i), 0);
        settle("saturate");
        check("m_err_saturated", m_err, 2'b11);

        bp = 2;
        gap_max = 3;
        for (int i = 0; i < 400; i++)
            send($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom, 2'($urandom_range(0, 3)));
        send(0, 1, 32'hfeedf00d, 0);
        settle("random");

        bp = 0;
        gap_max = 0;
        send(1, 0, 32'he0000001, 0);
        send(0, 0, 32'he0000002, 0);
        send(0, 0, 32'he0000003, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        reset_checks("mid_reset");
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_no_output", outs[0] + outs[1], 0);
        check("post_reset_idle", {m_out.valid, r_out.valid}, 0);
        @(posedge clk); #1;
        send(0, 1, 32'h77770000, 0);
        send(1, 0, 32'h88880001, 0);
        send(0, 1, 32'h88880002, 0);
        settle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
